// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: initiator side of the 32-bit ALU interface.
// Takes one command at a time, holds the operands on the alu inputs long
// enough for the ripple-carry path to settle, captures the result and flags,
// and returns them over a valid/ready response port.
module alu_op_sequencer #(
  parameter int WIDTH  = 32,
  parameter int SETTLE = 40,
  parameter int CNT_W  = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [WIDTH-1:0] i_cmd_x,
  input  logic [WIDTH-1:0] i_cmd_y,
  input  logic [2:0]       i_cmd_op,
  output logic [WIDTH-1:0] o_alu_x,
  output logic [WIDTH-1:0] o_alu_y,
  output logic [2:0]       o_alu_opcode,
  input  logic [WIDTH-1:0] i_alu_f,
  input  logic             i_alu_overflow,
  input  logic             i_alu_cout,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic [WIDTH-1:0] o_rsp_f,
  output logic             o_rsp_overflow,
  output logic             o_rsp_cout,
  output logic             o_rsp_zero,
  output logic             o_rsp_illegal,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_op_count
);

  // The settle counter is loaded with SETTLE and captures when it reads zero,
  // so the response appears SETTLE+1 edges after the accept edge: SETTLE
  // full cycles of stable alu inputs plus the launch cycle of the alu_* register.
  localparam int SW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           r_state;
  logic [SW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_alu_x;
  logic [WIDTH-1:0] r_alu_y;
  logic [2:0]       r_alu_opcode;
  logic [WIDTH-1:0] r_rsp_f;
  logic             r_rsp_overflow;
  logic             r_rsp_cout;
  logic             r_rsp_zero;
  logic             r_rsp_illegal;
  logic [CNT_W-1:0] r_op_count;

  logic w_accept;
  logic w_legal;
  logic w_logic_op;

  assign o_cmd_ready = (r_state == IDLE) && !i_rst;
  assign w_accept    = i_cmd_valid && o_cmd_ready;
  assign w_legal     = (i_cmd_op <= 3'd4);
  // OR and AND have no meaningful carry chain, so their flags are suppressed.
  assign w_logic_op  = (r_alu_opcode == 3'b001) || (r_alu_opcode == 3'b010);

  assign o_alu_x        = r_alu_x;
  assign o_alu_y        = r_alu_y;
  assign o_alu_opcode   = r_alu_opcode;
  assign o_rsp_valid    = (r_state == RESP);
  assign o_rsp_f        = r_rsp_f;
  assign o_rsp_overflow = r_rsp_overflow;
  assign o_rsp_cout     = r_rsp_cout;
  assign o_rsp_zero     = r_rsp_zero;
  assign o_rsp_illegal  = r_rsp_illegal;
  assign o_busy         = (r_state != IDLE);
  assign o_op_count     = r_op_count;

  // Sequencer FSM: accept, settle, capture, hand back; all outputs registered here.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_alu_x        <= '0;
      r_alu_y        <= '0;
      r_alu_opcode   <= '0;
      r_rsp_f        <= '0;
      r_rsp_overflow <= 1'b0;
      r_rsp_cout     <= 1'b0;
      r_rsp_zero     <= 1'b0;
      r_rsp_illegal  <= 1'b0;
      r_op_count     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_legal) begin
              r_alu_x       <= i_cmd_x;
              r_alu_y       <= i_cmd_y;
              r_alu_opcode  <= i_cmd_op;
              r_cnt         <= SETTLE_LOAD;
              r_rsp_illegal <= 1'b0;
              r_state       <= WAIT;
            end else begin
              // Rejected opcodes never reach the alu; answer immediately.
              r_rsp_f        <= '0;
              r_rsp_overflow <= 1'b0;
              r_rsp_cout     <= 1'b0;
              r_rsp_zero     <= 1'b1;
              r_rsp_illegal  <= 1'b1;
              r_state        <= RESP;
            end
          end
        end
        WAIT: begin
          if (r_cnt == '0) begin
            r_rsp_f        <= i_alu_f;
            r_rsp_overflow <= w_logic_op ? 1'b0 : i_alu_overflow;
            r_rsp_cout     <= w_logic_op ? 1'b0 : i_alu_cout;
            r_rsp_zero     <= ~|i_alu_f;
            r_state        <= RESP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RESP: begin
          if (i_rsp_ready) begin
            r_op_count <= r_op_count + CNT_W'(1);
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: table-driven bench with a scoreboard queue for
// alu_op_sequencer, driving a behavioural stand-in for the gate-level alu.
module tb_alu_op_sequencer;

  localparam int WIDTH  = 32;
  localparam int SETTLE = 8;
  localparam int CNT_W  = 16;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] f;
    logic        ovf;
    logic        cout;
    logic        zero;
    logic        illegal;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmdValid;
  logic             cmdReady;
  logic [WIDTH-1:0] cmdX;
  logic [WIDTH-1:0] cmdY;
  logic [2:0]       cmdOp;
  logic [WIDTH-1:0] aluX;
  logic [WIDTH-1:0] aluY;
  logic [2:0]       aluOpcode;
  logic [WIDTH-1:0] aluF;
  logic             aluOvf;
  logic             aluCout;
  logic             rspValid;
  logic             rspReady;
  logic [WIDTH-1:0] rspF;
  logic             rspOvf;
  logic             rspCout;
  logic             rspZero;
  logic             rspIllegal;
  logic             busy;
  logic [CNT_W-1:0] opCount;

  int checks = 0;
  int errors = 0;
  int expCount = 0;
  logic [31:0] expAluX = '0;
  logic [31:0] expAluY = '0;
  logic [2:0]  expAluOp = '0;
  vec_t sb[$];
  vec_t vecs[13];

  alu_op_sequencer #(.WIDTH(WIDTH), .SETTLE(SETTLE), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_cmd_valid(cmdValid), .o_cmd_ready(cmdReady),
    .i_cmd_x(cmdX), .i_cmd_y(cmdY), .i_cmd_op(cmdOp),
    .o_alu_x(aluX), .o_alu_y(aluY), .o_alu_opcode(aluOpcode),
    .i_alu_f(aluF), .i_alu_overflow(aluOvf), .i_alu_cout(aluCout),
    .o_rsp_valid(rspValid), .i_rsp_ready(rspReady),
    .o_rsp_f(rspF), .o_rsp_overflow(rspOvf), .o_rsp_cout(rspCout),
    .o_rsp_zero(rspZero), .o_rsp_illegal(rspIllegal),
    .o_busy(busy), .o_op_count(opCount)
  );

  always #5 clk = ~clk;

  // Stand-in alu: flags always come from the adder, even for OR/AND, so the
  // sequencer's flag suppression is visible; overflow also asserts on carry-out.
  logic [WIDTH:0] aluSum;
  logic           aluSov;
  always_comb begin
    aluSum = '0;
    aluSov = 1'b0;
    aluF   = 32'hDEADBEEF;
    if (aluOpcode == 3'b011 || aluOpcode == 3'b100) begin
      aluSum = {1'b0, aluX} + {1'b0, ~aluY} + 33'd1;
      aluSov = (aluX[31] != aluY[31]) && (aluSum[31] != aluX[31]);
    end else begin
      aluSum = {1'b0, aluX} + {1'b0, aluY};
      aluSov = (aluX[31] == aluY[31]) && (aluSum[31] != aluX[31]);
    end
    case (aluOpcode)
      3'b000, 3'b011: aluF = aluSum[31:0];
      3'b001:         aluF = aluX | aluY;
      3'b010:         aluF = aluX & aluY;
      3'b100:         aluF = {31'b0, ($signed(aluX) < $signed(aluY))};
      default:        aluF = 32'hDEADBEEF;
    endcase
    aluCout = aluSum[32];
    aluOvf  = aluSov | aluSum[32];
  end

  // Safety net so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mkVec(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                                 input logic [31:0] f, input logic ovf, input logic cout,
                                 input logic zero, input logic illegal);
    vec_t v;
    v.op = op; v.x = x; v.y = y; v.f = f;
    v.ovf = ovf; v.cout = cout; v.zero = zero; v.illegal = illegal;
    return v;
  endfunction

  task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Drive one command, wait (bounded) for acceptance and push its expectation.
  task automatic applyStimulus(input vec_t v);
    logic ready;
    bit accepted;
    accepted = 0;
    cmdValid = 1'b1;
    cmdX = v.x;
    cmdY = v.y;
    cmdOp = v.op;
    for (int i = 0; i < 100; i++) begin
      ready = cmdReady;
      @(posedge clk);
      #1;
      if (ready) begin
        accepted = 1;
        break;
      end
    end
    cmdValid = 1'b0;
    if (accepted) begin
      sb.push_back(v);
      if (v.op <= 3'd4) begin
        expAluX = v.x;
        expAluY = v.y;
        expAluOp = v.op;
      end
    end else begin
      checks++;
      errors++;
      $display("[TB] FAIL cmd_accept actual=not_accepted required=accepted");
    end
  endtask

  // Wait for the response, compare against the scoreboard, optionally stall, then handshake.
  task automatic checkOutput(input int holdCycles);
    vec_t e;
    int lat;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard actual=empty required=entry");
      return;
    end
    e = sb.pop_front();
    lat = 0;
    while (!rspValid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkEq("rsp_latency", 32'(lat), 32'(e.illegal ? 0 : SETTLE + 1));
    if (!rspValid) return;
    checkEq("rsp_f", rspF, e.f);
    checkEq("rsp_overflow", 32'(rspOvf), 32'(e.ovf));
    checkEq("rsp_cout", 32'(rspCout), 32'(e.cout));
    checkEq("rsp_zero", 32'(rspZero), 32'(e.zero));
    checkEq("rsp_illegal", 32'(rspIllegal), 32'(e.illegal));
    checkEq("alu_x", aluX, expAluX);
    checkEq("alu_y", aluY, expAluY);
    checkEq("alu_opcode", 32'(aluOpcode), 32'(expAluOp));
    checkEq("busy_in_resp", 32'(busy), 32'd1);
    for (int i = 0; i < holdCycles; i++) begin
      @(posedge clk);
      #1;
      checkEq("hold_rsp_valid", 32'(rspValid), 32'd1);
      checkEq("hold_rsp_f", rspF, e.f);
      checkEq("hold_cmd_ready", 32'(cmdReady), 32'd0);
      checkEq("hold_alu_x", aluX, expAluX);
    end
    rspReady = 1'b1;
    @(posedge clk);
    #1;
    rspReady = 1'b0;
    expCount++;
    checkEq("op_count", 32'(opCount), 32'(expCount));
    checkEq("rsp_valid_drop", 32'(rspValid), 32'd0);
    checkEq("cmd_ready_idle", 32'(cmdReady), 32'd1);
  endtask

  initial begin
    bit sawValid;
    vecs[0]  = mkVec(3'b000, 32'd1024,      32'd128,       32'd1152,      1'b0, 1'b0, 1'b0, 1'b0);
    vecs[1]  = mkVec(3'b000, 32'hFFFFFFFF,  32'd1,         32'h00000000,  1'b1, 1'b1, 1'b1, 1'b0);
    vecs[2]  = mkVec(3'b000, 32'h7FFFFFFF,  32'd1,         32'h80000000,  1'b1, 1'b0, 1'b0, 1'b0);
    vecs[3]  = mkVec(3'b011, 32'd121,       32'd161,       32'hFFFFFFD8,  1'b0, 1'b0, 1'b0, 1'b0);
    vecs[4]  = mkVec(3'b100, 32'd71,        32'd57,        32'd0,         1'b1, 1'b1, 1'b1, 1'b0);
    vecs[5]  = mkVec(3'b100, 32'd14507,     32'd97400,     32'd1,         1'b0, 1'b0, 1'b0, 1'b0);
    vecs[6]  = mkVec(3'b001, 32'hFFFFFFFF,  32'd1,         32'hFFFFFFFF,  1'b0, 1'b0, 1'b0, 1'b0);
    vecs[7]  = mkVec(3'b010, 32'hFFFFFFFF,  32'h80000000,  32'h80000000,  1'b0, 1'b0, 1'b0, 1'b0);
    vecs[8]  = mkVec(3'b010, 32'h000000F0,  32'h0000000F,  32'd0,         1'b0, 1'b0, 1'b1, 1'b0);
    vecs[9]  = mkVec(3'b110, 32'd1234,      32'd5678,      32'd0,         1'b0, 1'b0, 1'b1, 1'b1);
    vecs[10] = mkVec(3'b011, 32'd5,         32'd5,         32'd0,         1'b1, 1'b1, 1'b1, 1'b0);
    vecs[11] = mkVec(3'b111, 32'hAAAA5555,  32'h12345678,  32'd0,         1'b0, 1'b0, 1'b1, 1'b1);
    vecs[12] = mkVec(3'b000, 32'd2,         32'd3,         32'd5,         1'b0, 1'b0, 1'b0, 1'b0);

    rst = 1'b1;
    cmdValid = 1'b0;
    cmdX = '0;
    cmdY = '0;
    cmdOp = '0;
    rspReady = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    checkEq("reset_cmd_ready", 32'(cmdReady), 32'd0);
    checkEq("reset_rsp_valid", 32'(rspValid), 32'd0);
    checkEq("reset_busy", 32'(busy), 32'd0);
    checkEq("reset_op_count", 32'(opCount), 32'd0);
    checkEq("reset_alu_x", aluX, 32'd0);
    checkEq("reset_rsp_f", rspF, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkEq("idle_cmd_ready", 32'(cmdReady), 32'd1);

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i]);
      checkOutput(0);
    end

    // Response stalled with a second command already waiting.
    applyStimulus(mkVec(3'b000, 32'd100, 32'd200, 32'd300, 1'b0, 1'b0, 1'b0, 1'b0));
    cmdValid = 1'b1;
    cmdX = 32'd3;
    cmdY = 32'd12;
    cmdOp = 3'b001;
    checkOutput(5);
    applyStimulus(mkVec(3'b001, 32'd3, 32'd12, 32'd15, 1'b0, 1'b0, 1'b0, 1'b0));
    checkOutput(0);

    // Reset pulsed while waiting for the alu to settle.
    applyStimulus(mkVec(3'b000, 32'd10, 32'd20, 32'd30, 1'b0, 1'b0, 1'b0, 1'b0));
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkEq("midrst_cmd_ready", 32'(cmdReady), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    expCount = 0;
    expAluX = '0;
    expAluY = '0;
    expAluOp = '0;
    checkEq("midrst_rsp_valid", 32'(rspValid), 32'd0);
    checkEq("midrst_busy", 32'(busy), 32'd0);
    checkEq("midrst_op_count", 32'(opCount), 32'd0);
    checkEq("midrst_alu_x", aluX, 32'd0);
    checkEq("midrst_alu_y", aluY, 32'd0);
    checkEq("midrst_rsp_f", rspF, 32'd0);
    checkEq("midrst_flags", 32'({rspOvf, rspCout, rspZero, rspIllegal}), 32'd0);
    sawValid = 0;
    for (int i = 0; i < SETTLE + 4; i++) begin
      @(posedge clk);
      #1;
      if (rspValid) sawValid = 1;
    end
    checkEq("midrst_no_response", 32'(sawValid), 32'd0);
    applyStimulus(mkVec(3'b001, 32'h000000F0, 32'h0000000F, 32'h000000FF, 1'b0, 1'b0, 1'b0, 1'b0));
    checkOutput(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
